adc_spi_responder: RTL
======================

# adc_spi_responder

Serial-ADC responder that emulates the two-channel 12-bit SPI ADC that the design's ADC interface polls for dial and CdS readings. It sits on the far side of the `adc_cs_n` / `adc_sclk` / `adc_din` / `adc_data_in` pins. It decodes the master's command and shifts back a sample taken from parallel inputs. It serves as the loopback target for board bring-up and as the bus-functional peer in the system bench.

## Interface

- `DATA_BITS`, 12, sample width returned per frame.
- `SYNC_STAGES`, 2, synchronizer depth on `adc_cs_n`, `adc_sclk` and `adc_din`.
- `clk` in 1: system clock, 50 MHz.
- `sys_rst` in 1: synchronous, active-high reset.
- `adc_cs_n` in 1: chip select from the master, active low, asynchronous to `clk`.
- `adc_sclk` in 1: serial clock from the master, idles low, asynchronous to `clk`.
- `adc_din` in 1: command bits from the master (MOSI).
- `adc_dout` out 1: response bits to the master (MISO; the master's `adc_data_in`).
- `adc_dout_oe` out 1: output enable, high while selected and driving.
- `ch0_value` in 12: sample returned for channel 0 (dial).
- `ch1_value` in 12: sample returned for channel 1 (CdS).
- `frame_done` out 1: one-cycle pulse when a frame completes.
- `frame_abort` out 1: one-cycle pulse when `adc_cs_n` rises mid-frame.
- `last_cmd` out 3: {SGL, ODD, MSBF} of the last decoded command.
- `frame_count` out 8: completed-frame counter, wraps 255→0.

## Operation

- Numbering: "rise k" is the k-th synchronized `adc_sclk` rising edge since `adc_cs_n` fell. "fall k" is the falling edge that follows rise k.
- States: IDLE, WAIT_START, CMD, NULLBIT, DATA_MSB, DATA_LSB, TRAIL.
- IDLE: `adc_dout_oe`=0, `adc_dout`=0. Synced `adc_cs_n` fall → WAIT_START with `adc_dout_oe`=1.
- WAIT_START: on each rising edge, `adc_din`=0 is ignored (leading zeros). `adc_din`=1 is the start bit → CMD.
- CMD: samples SGL, ODD and MSBF on the next three rising edges.
  - On the MSBF edge, load the `last_cmd` register and snapshot the sample into the shift register, then → NULLBIT.
  - SGL=1: sample = ODD ? `ch1_value` : `ch0_value`.
  - SGL=0, ODD=0: sample = `ch0_value` − `ch1_value`, saturated to 0 when negative.
  - SGL=0, ODD=1: sample = `ch1_value` − `ch0_value`, saturated to 0 when negative.
  - Subtraction is performed at 13 bits; the sign bit selects saturation.
- NULLBIT: next falling edge drives 0 → DATA_MSB.
- DATA_MSB: falling edges drive B11 down to B0, one bit per edge.
  - After B0 with MSBF=1: the next falling edge → TRAIL with a `frame_done` pulse.
  - After B0 with MSBF=0 → DATA_LSB.
- DATA_LSB: falling edges drive B1 up to B11, one bit per edge. The falling edge after B11 → TRAIL with `frame_done`.
- TRAIL: drives 0 until `adc_cs_n` rises → IDLE.
- `frame_count` increments on each `frame_done`.
- Synced `adc_cs_n` rise in any state other than IDLE or TRAIL → IDLE with a `frame_abort` pulse. `frame_count` and `last_cmd` are unchanged; `adc_dout_oe` drops on the same cycle.
- `ch0_value` and `ch1_value` changes after the snapshot do not affect the frame in flight.

## Timing

- Each pin passes `SYNC_STAGES` flops, then an edge-detect flop.
  - A pin edge is acted on 3 `clk` cycles later.
  - `adc_dout` changes 3 cycles after the physical `adc_sclk` fall.
- Master requirement: `adc_sclk` high and low times of at least 8 `clk` cycles each (≤3.125 MHz).
- `adc_cs_n` falling and `adc_sclk` rising in the same synchronized cycle: CS is processed first. That rising edge counts as rise 1.
- `adc_cs_n` rising and an `adc_sclk` edge in the same cycle: abort wins, and no bit is sampled or driven.
- Reset values: state IDLE, `adc_dout`=0, `adc_dout_oe`=0, `frame_done`=0, `frame_abort`=0, `last_cmd`=3'b000, `frame_count`=0, synchronizers=idle levels (cs_n=1, sclk=0, din=0).
- `sys_rst` mid-frame: IDLE on the next cycle with no `frame_abort` pulse. A new frame then requires a fresh `adc_cs_n` fall.

## Structure

- Shared package `adc_spi_pkg`:
  - state enum
  - `CMD_BITS`=3 and `DATA_BITS`=12
  - the SGL/ODD/MSBF bit positions, shared with the master-side interface
- Sub-module `spi_pin_sync`: `SYNC_STAGES` flops plus rise/fall detect, instantiated once each for `adc_cs_n`, `adc_sclk` and `adc_din` (edge outputs unused for din).
- The FSM, snapshot/subtract logic, shift register and counters live in the top of the block.

## Test plan

- Single-ended CH0 with MSBF=1: `ch0_value`=12'hA5C, command bits 1,1,0,1. Expect `adc_dout` 0 then 1010_0101_1100 on falls 4–16, `frame_done` once, `frame_count`=1, `last_cmd`=3'b101.
- Differential saturation: `ch0_value`=100, `ch1_value`=300, SGL=0, ODD=0. Expect 12'h000 returned. With ODD=1, expect 12'h0C8.
- MSBF=0 on CH1 with `ch1_value`=12'h801: expect MSB-first 1000_0000_0001, then LSB-first 0,0,0,0,0,0,0,0,0,0,1 (B1–B11), then `frame_done` on fall 28.
- Three leading zeros before the start bit, plus `ch0_value` changed mid-DATA: expect the frame unaffected, returning the snapshot value.
- `adc_cs_n` raised after fall 8: expect a `frame_abort` pulse, `adc_dout_oe`=0 three cycles after the pin edge, `frame_count` unchanged. The next full frame then completes normally.
- 256 back-to-back frames: `frame_count` wraps to 0. A `sys_rst` pulse mid-frame returns all outputs to reset values with no abort pulse.

Source files
------------

// File: rtl/adc_spi_pkg.sv
// adc_spi_pkg
// Definitions shared by the serial-ADC responder and the master-side ADC
// interface: responder state encoding, command/sample widths and the bit
// positions of SGL, ODD and MSBF inside the decoded command word.
package adc_spi_pkg;

    localparam int CMD_BITS  = 3;
    localparam int DATA_BITS = 12;

    // Positions inside the {SGL, ODD, MSBF} command word
    localparam int CMD_SGL_POS  = 2;
    localparam int CMD_ODD_POS  = 1;
    localparam int CMD_MSBF_POS = 0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_START,
        ST_CMD,
        ST_NULLBIT,
        ST_DATA_MSB,
        ST_DATA_LSB,
        ST_TRAIL
    } adc_state_e;

endpackage

// File: rtl/spi_pin_sync.sv
// spi_pin_sync
// Brings one asynchronous SPI pin into the clk domain through SYNC_STAGES
// flops, then compares against one more flop to flag edges.
//   clk, sys_rst : system clock, synchronous active-high reset
//   pin_in       : raw asynchronous pin
//   level        : synchronized pin level
//   rise / fall  : single-cycle edge flags, aligned with level
module spi_pin_sync #(
    parameter int   SYNC_STAGES = 2,
    parameter logic IDLE_LEVEL  = 1'b0
) (
    input  logic clk,
    input  logic sys_rst,
    input  logic pin_in,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;

    always_comb begin
        sync_d = (sync_q << 1) | SYNC_STAGES'(pin_in);
        prev_d = sync_q[SYNC_STAGES-1];
    end

    // Reset to the pin's idle level so no phantom edge is seen after reset
    always_ff @(posedge clk) begin
        if (sys_rst) begin
            sync_q <= {SYNC_STAGES{IDLE_LEVEL}};
            prev_q <= IDLE_LEVEL;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign level = sync_q[SYNC_STAGES-1];
    assign rise  = level & ~prev_q;
    assign fall  = ~level & prev_q;

endmodule

// File: rtl/adc_spi_responder.sv
// adc_spi_responder
// Emulates a two-channel 12-bit SPI ADC. Decodes {start, SGL, ODD, MSBF}
// from the master, snapshots a single-ended or saturated differential sample
// and shifts it back MSB-first (optionally followed by an LSB-first replay).
//   clk, sys_rst          : system clock, synchronous active-high reset
//   adc_cs_n/sclk/din     : asynchronous master pins (CS, SCLK, MOSI)
//   adc_dout, adc_dout_oe : MISO and its output enable
//   ch0_value, ch1_value  : parallel channel samples
//   frame_done/abort      : one-cycle status pulses
//   last_cmd              : {SGL, ODD, MSBF} of the last decoded command
//   frame_count           : completed frames, wraps at 256
module adc_spi_responder #(
    parameter int DATA_BITS   = 12,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 sys_rst,
    input  logic                 adc_cs_n,
    input  logic                 adc_sclk,
    input  logic                 adc_din,
    output logic                 adc_dout,
    output logic                 adc_dout_oe,
    input  logic [DATA_BITS-1:0] ch0_value,
    input  logic [DATA_BITS-1:0] ch1_value,
    output logic                 frame_done,
    output logic                 frame_abort,
    output logic [2:0]           last_cmd,
    output logic [7:0]           frame_count
);

    import adc_spi_pkg::*;

    localparam int CNT_W = $clog2(DATA_BITS + 1);

    logic cs_lvl_unused, cs_rise, cs_fall;
    logic sclk_lvl_unused, sclk_rise, sclk_fall;
    logic din_lvl, din_rise_unused, din_fall_unused;

    spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .IDLE_LEVEL(1'b1)) u_sync_cs (
        .clk(clk), .sys_rst(sys_rst), .pin_in(adc_cs_n),
        .level(cs_lvl_unused), .rise(cs_rise), .fall(cs_fall)
    );

    spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .IDLE_LEVEL(1'b0)) u_sync_sclk (
        .clk(clk), .sys_rst(sys_rst), .pin_in(adc_sclk),
        .level(sclk_lvl_unused), .rise(sclk_rise), .fall(sclk_fall)
    );

    spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .IDLE_LEVEL(1'b0)) u_sync_din (
        .clk(clk), .sys_rst(sys_rst), .pin_in(adc_din),
        .level(din_lvl), .rise(din_rise_unused), .fall(din_fall_unused)
    );

    adc_state_e           state_q, state_d;
    logic                 dout_q, dout_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [1:0]           cmd_q, cmd_d;
    logic [DATA_BITS-1:0] sample_q, sample_d;
    logic [2:0]           last_cmd_q, last_cmd_d;
    logic                 done_q, done_d;
    logic                 abort_q, abort_d;
    logic [7:0]           count_q, count_d;

    logic [DATA_BITS:0]   diff_01, diff_10;
    logic [DATA_BITS-1:0] snap;

    // Sample selected by the SGL/ODD bits collected so far; the extra top
    // bit of each difference is the borrow that forces saturation to zero.
    always_comb begin
        diff_01 = {1'b0, ch0_value} - {1'b0, ch1_value};
        diff_10 = {1'b0, ch1_value} - {1'b0, ch0_value};
        if (cmd_q[1]) begin
            snap = cmd_q[0] ? ch1_value : ch0_value;
        end else if (cmd_q[0]) begin
            snap = diff_10[DATA_BITS] ? '0 : diff_10[DATA_BITS-1:0];
        end else begin
            snap = diff_01[DATA_BITS] ? '0 : diff_01[DATA_BITS-1:0];
        end
    end

    // cnt_q counts command bits in CMD, the remaining MSB-first bits in
    // DATA_MSB (12 down to 0) and the next LSB-first bit index in DATA_LSB.
    always_comb begin
        state_d    = state_q;
        dout_d     = dout_q;
        cnt_d      = cnt_q;
        cmd_d      = cmd_q;
        sample_d   = sample_q;
        last_cmd_d = last_cmd_q;
        done_d     = 1'b0;
        abort_d    = 1'b0;
        count_d    = count_q;

        case (state_q)
            ST_IDLE: begin
                dout_d = 1'b0;
                // A coincident SCLK rise is the first rise of the new frame
                if (cs_fall) begin
                    state_d = ST_WAIT_START;
                    if (sclk_rise && din_lvl) begin
                        state_d = ST_CMD;
                        cnt_d   = '0;
                    end
                end
            end
            ST_TRAIL: begin
                dout_d = 1'b0;
                if (cs_rise) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                // Deselect mid-frame wins over any SCLK edge in the same cycle
                if (cs_rise) begin
                    state_d = ST_IDLE;
                    dout_d  = 1'b0;
                    abort_d = 1'b1;
                end else begin
                    case (state_q)
                        ST_WAIT_START: begin
                            if (sclk_rise && din_lvl) begin
                                state_d = ST_CMD;
                                cnt_d   = '0;
                            end
                        end
                        ST_CMD: begin
                            if (sclk_rise) begin
                                if (cnt_q == CNT_W'(CMD_BITS - 1)) begin
                                    last_cmd_d[CMD_SGL_POS]  = cmd_q[1];
                                    last_cmd_d[CMD_ODD_POS]  = cmd_q[0];
                                    last_cmd_d[CMD_MSBF_POS] = din_lvl;
                                    sample_d = snap;
                                    state_d  = ST_NULLBIT;
                                end else begin
                                    cmd_d = {cmd_q[0], din_lvl};
                                    cnt_d = cnt_q + CNT_W'(1);
                                end
                            end
                        end
                        ST_NULLBIT: begin
                            if (sclk_fall) begin
                                dout_d  = 1'b0;
                                cnt_d   = CNT_W'(DATA_BITS);
                                state_d = ST_DATA_MSB;
                            end
                        end
                        ST_DATA_MSB: begin
                            if (sclk_fall) begin
                                if (cnt_q == '0) begin
                                    dout_d  = 1'b0;
                                    state_d = ST_TRAIL;
                                    done_d  = 1'b1;
                                    count_d = count_q + 8'd1;
                                end else begin
                                    dout_d = sample_q[cnt_q - CNT_W'(1)];
                                    cnt_d  = cnt_q - CNT_W'(1);
                                    // B0 just went out: LSB-first replay starts at B1
                                    if (cnt_q == CNT_W'(1) && !last_cmd_q[CMD_MSBF_POS]) begin
                                        state_d = ST_DATA_LSB;
                                        cnt_d   = CNT_W'(1);
                                    end
                                end
                            end
                        end
                        ST_DATA_LSB: begin
                            if (sclk_fall) begin
                                if (cnt_q == CNT_W'(DATA_BITS)) begin
                                    dout_d  = 1'b0;
                                    state_d = ST_TRAIL;
                                    done_d  = 1'b1;
                                    count_d = count_q + 8'd1;
                                end else begin
                                    dout_d = sample_q[cnt_q];
                                    cnt_d  = cnt_q + CNT_W'(1);
                                end
                            end
                        end
                        default: begin
                        end
                    endcase
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (sys_rst) begin
            state_q    <= ST_IDLE;
            dout_q     <= 1'b0;
            cnt_q      <= '0;
            cmd_q      <= '0;
            sample_q   <= '0;
            last_cmd_q <= '0;
            done_q     <= 1'b0;
            abort_q    <= 1'b0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            dout_q     <= dout_d;
            cnt_q      <= cnt_d;
            cmd_q      <= cmd_d;
            sample_q   <= sample_d;
            last_cmd_q <= last_cmd_d;
            done_q     <= done_d;
            abort_q    <= abort_d;
            count_q    <= count_d;
        end
    end

    assign adc_dout    = dout_q;
    assign adc_dout_oe = (state_q != ST_IDLE);
    assign frame_done  = done_q;
    assign frame_abort = abort_q;
    assign last_cmd    = last_cmd_q;
    assign frame_count = count_q;

endmodule
